cvxif_copro_issue_unit: RTL

CV-X-IF coprocessor that sits directly downstream of the core's coprocessor interface. It consumes issue requests and commit/kill notifications, holds speculative operands until commit, and executes a small custom-0 ALU op set. Results return in commit order through a buffered valid/ready result channel. Flat ports; the integration wrapper packs and unpacks the cvxif request/response structs.

---
 rtl/cvxif_copro_issue_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cvxif_copro_issue_unit.sv
// CV-X-IF coprocessor: decodes custom-0 ALU ops, parks speculative operands per ID
// until commit/kill, and returns results in commit order through a FWFT result FIFO.
module cvxif_copro_issue_unit #(
    parameter int XLEN     = 64,
    parameter int IdWidth  = 3,
    parameter int ResDepth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic               busy_o
);
    localparam int NumSlots = 2 ** IdWidth;
    localparam int PtrW     = $clog2(ResDepth);
    localparam int ShW      = $clog2(XLEN);
    localparam int WbCntW   = IdWidth + 1;
    localparam int FifoCntW = PtrW + 1;
    localparam int SumW     = ((WbCntW > FifoCntW) ? WbCntW : FifoCntW) + 1;

    function automatic logic [XLEN-1:0] alu(input logic [2:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a ^ b;
            3'd3:    r = a & b;
            3'd4:    r = a << b[ShW-1:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Pending table
    logic [NumSlots-1:0] pend_valid_reg;
    logic [NumSlots-1:0] pend_wb_reg;
    logic [2:0]          pend_op_reg  [NumSlots];
    logic [4:0]          pend_rd_reg  [NumSlots];
    logic [XLEN-1:0]     pend_rs1_reg [NumSlots];
    logic [XLEN-1:0]     pend_rs2_reg [NumSlots];
    logic [WbCntW-1:0]   wb_pending_reg, wb_pending_next;

    // Result FIFO
    logic [IdWidth-1:0]  fifo_id_reg   [ResDepth];
    logic [4:0]          fifo_rd_reg   [ResDepth];
    logic [XLEN-1:0]     fifo_data_reg [ResDepth];
    logic [PtrW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [FifoCntW-1:0] fifo_count_reg, fifo_count_next;

    logic [2:0]  dec_funct3;
    logic        dec_legal;
    logic        issue_fire, bypass, store, commit_hit, push, pop;
    logic        wb_inc, wb_dec;
    logic [SumW-1:0] credit_used;
    logic [2:0]      exec_op;
    logic [XLEN-1:0] exec_a, exec_b;
    logic [4:0]      push_rd;
    logic [NumSlots-1:0] slot_set, slot_clr;

    assign dec_funct3        = issue_instr_i[14:12];
    assign dec_legal         = (issue_instr_i[6:0] == 7'b0001011) && (issue_instr_i[31:25] == 7'd0)
                               && ((dec_funct3 <= 3'd4) || (dec_funct3 == 3'd7));
    assign issue_accept_o    = dec_legal;
    assign issue_writeback_o = dec_legal && (dec_funct3 != 3'd7);

    // Outstanding writebacks plus buffered results never exceed the FIFO depth.
    assign credit_used   = SumW'(wb_pending_reg) + SumW'(fifo_count_reg);
    assign issue_ready_o = !pend_valid_reg[issue_id_i] && (credit_used < SumW'(ResDepth));

    assign issue_fire = issue_valid_i && issue_ready_o && dec_legal;
    assign bypass     = issue_fire && commit_valid_i && (commit_id_i == issue_id_i);
    assign store      = issue_fire && !bypass;
    assign commit_hit = commit_valid_i && pend_valid_reg[commit_id_i];
    assign push       = (commit_hit && !commit_kill_i && pend_wb_reg[commit_id_i])
                        || (bypass && !commit_kill_i && issue_writeback_o);
    assign pop        = result_valid_o && result_ready_i;
    assign wb_inc     = store && issue_writeback_o;
    assign wb_dec     = commit_hit && pend_wb_reg[commit_id_i];

    assign exec_op = bypass ? dec_funct3          : pend_op_reg[commit_id_i];
    assign exec_a  = bypass ? issue_rs1_i         : pend_rs1_reg[commit_id_i];
    assign exec_b  = bypass ? issue_rs2_i         : pend_rs2_reg[commit_id_i];
    assign push_rd = bypass ? issue_instr_i[11:7] : pend_rd_reg[commit_id_i];

    genvar gi;
    generate
        for (gi = 0; gi < NumSlots; gi++) begin : g_slot
            assign slot_set[gi] = store && (issue_id_i == IdWidth'(gi));
            assign slot_clr[gi] = commit_hit && (commit_id_i == IdWidth'(gi));
        end
    endgenerate

    always_comb begin
        wb_pending_next = wb_pending_reg;
        if (wb_inc && !wb_dec)
            wb_pending_next = wb_pending_reg + WbCntW'(1);
        else if (wb_dec && !wb_inc)
            wb_pending_next = wb_pending_reg - WbCntW'(1);
    end

    always_comb begin
        fifo_count_next = fifo_count_reg;
        if (push && !pop)
            fifo_count_next = fifo_count_reg + FifoCntW'(1);
        else if (pop && !push)
            fifo_count_next = fifo_count_reg - FifoCntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_valid_reg <= '0;
            pend_wb_reg    <= '0;
            wb_pending_reg <= '0;
            fifo_count_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
        end else begin
            // A slot is never set and cleared in one cycle: set needs it empty, clear needs it full.
            pend_valid_reg <= (pend_valid_reg | slot_set) & ~slot_clr;
            if (store)
                pend_wb_reg[issue_id_i] <= issue_writeback_o;
            wb_pending_reg <= wb_pending_next;
            fifo_count_reg <= fifo_count_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) begin
            pend_op_reg[issue_id_i]  <= dec_funct3;
            pend_rd_reg[issue_id_i]  <= issue_instr_i[11:7];
            pend_rs1_reg[issue_id_i] <= issue_rs1_i;
            pend_rs2_reg[issue_id_i] <= issue_rs2_i;
        end
        if (push) begin
            fifo_id_reg[wr_ptr_reg]   <= commit_id_i;
            fifo_rd_reg[wr_ptr_reg]   <= push_rd;
            fifo_data_reg[wr_ptr_reg] <= alu(exec_op, exec_a, exec_b);
        end
    end

    assign result_valid_o = (fifo_count_reg != '0);
    assign result_id_o    = fifo_id_reg[rd_ptr_reg];
    assign result_rd_o    = fifo_rd_reg[rd_ptr_reg];
    assign result_data_o  = fifo_data_reg[rd_ptr_reg];
    assign busy_o         = (|pend_valid_reg) || (fifo_count_reg != '0);

endmodule
